// File: rtl/multicore_mem_pkg.sv
// multicore_mem_pkg: shared widths and master indices for the on-chip RAM arbiter.
package multicore_mem_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; the master that did not win last gets priority.
module rr_arb2
  import multicore_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;
  always_comb begin
    gnt_o  = (&req_i) ? ((last_q == M1) ? 2'b01 : 2'b10) : req_i;
    last_d = advance_i ? gnt_o[1] : last_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) last_q <= M1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/multicore_onchip_arbiter.sv
// multicore_onchip_arbiter: shares a single-port on-chip RAM between two Avalon-MM masters,
// routing the one-cycle-latency read data back to the master that issued the read.
module multicore_onchip_arbiter
  import multicore_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);
  logic [1:0] req, gnt;
  logic       sel, sel_q, sel_d;
  logic       rd_acc, rd_pend_q, rd_pend_d, rd_owner_q, rd_owner_d;
  assign req = {reset_n & (m1_read | m1_write), reset_n & (m0_read | m0_write)};
  rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req),
    .advance_i(|gnt),
    .gnt_o    (gnt)
  );
  // Read+write together counts as a write, so only a pure read expects data back.
  always_comb begin
    sel        = (|gnt) ? gnt[1] : sel_q;
    sel_d      = sel;
    rd_acc     = (gnt[0] & m0_read & ~m0_write) | (gnt[1] & m1_read & ~m1_write);
    rd_pend_d  = rd_acc;
    rd_owner_d = rd_acc ? gnt[1] : rd_owner_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q      <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end
  assign ram_address      = sel ? m1_address : m0_address;
  assign ram_byteenable   = sel ? m1_byteenable : m0_byteenable;
  assign ram_writedata    = sel ? m1_writedata : m0_writedata;
  assign ram_chipselect   = |gnt;
  assign ram_write        = (gnt[0] & m0_write) | (gnt[1] & m1_write);
  assign ram_clken        = reset_n;
  assign m0_waitrequest   = ~reset_n | ((m0_read | m0_write) & ~gnt[0]);
  assign m1_waitrequest   = ~reset_n | ((m1_read | m1_write) & ~gnt[1]);
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  // Reset in the return cycle kills an in-flight read's strobe.
  assign m0_readdatavalid = reset_n & rd_pend_q & (rd_owner_q == M0);
  assign m1_readdatavalid = reset_n & rd_pend_q & (rd_owner_q == M1);
endmodule

// File: tb/tb_multicore_onchip_arbiter.sv
// tb_multicore_onchip_arbiter: directed test of the two-master RAM arbiter against a behavioural RAM.
module tb_multicore_onchip_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  m0_address, m1_address, ram_address;
  logic [3:0]  m0_byteenable, m1_byteenable, ram_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, ram_writedata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_readdata = '0;
  logic [31:0] mem [0:1023];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  multicore_onchip_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_writedata(ram_writedata),
    .ram_clken(ram_clken), .ram_readdata(ram_readdata)
  );
  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else ram_readdata <= mem[ram_address];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
    reset_n = 0;
    idle();
    repeat (2) @(negedge clk);
    m0_read = 1; m1_read = 1;
    #1;
    chk("rst_wait0", m0_waitrequest, 1);
    chk("rst_wait1", m1_waitrequest, 1);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_wr", ram_write, 0);
    chk("rst_clken", ram_clken, 0);
    chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
    // contention from reset: grants alternate m0,m1,...
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      reset_n = 1;
      m0_read = 1; m1_read = 1;
      m0_address = 10'h010 + 10'((i + 1) / 2);
      m1_address = 10'h020 + 10'(i / 2);
      #1;
      chk($sformatf("rr_wait0_%0d", i), m0_waitrequest, i % 2);
      chk($sformatf("rr_wait1_%0d", i), m1_waitrequest, 1 - i % 2);
      chk($sformatf("rr_addr_%0d", i), ram_address,
          (i % 2 == 0) ? 32'h010 + i / 2 : 32'h020 + i / 2);
      chk($sformatf("rr_rdv0_%0d", i), m0_readdatavalid, i % 2);
      chk($sformatf("rr_rdv1_%0d", i), m1_readdatavalid, (i > 0 && i % 2 == 0) ? 1 : 0);
      if (i % 2 == 1) chk($sformatf("rr_d0_%0d", i), m0_readdata, 32'hC0DE_0010 + i / 2);
      if (i > 0 && i % 2 == 0) chk($sformatf("rr_d1_%0d", i), m1_readdata, 32'hC0DE_0020 + i / 2 - 1);
    end
    @(negedge clk); idle(); #1;
    chk("rr_last_rdv1", m1_readdatavalid, 1);
    chk("rr_last_d1", m1_readdata, 32'hC0DE_0022);
    chk("rr_last_rdv0", m0_readdatavalid, 0);
    // m0 write then read back
    @(negedge clk); idle();
    m0_write = 1; m0_address = 10'h005; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'hF;
    #1;
    chk("w_wait0", m0_waitrequest, 0);
    chk("w_ramwr", ram_write, 1);
    chk("w_addr", ram_address, 32'h005);
    chk("w_data", ram_writedata, 32'hDEAD_BEEF);
    @(negedge clk); idle(); m0_read = 1; m0_address = 10'h005; #1;
    chk("r_wait0", m0_waitrequest, 0);
    chk("r_cs", ram_chipselect, 1);
    chk("r_ramwr", ram_write, 0);
    chk("w_nordv", m0_readdatavalid, 0);
    @(negedge clk); idle(); #1;
    chk("r_rdv0", m0_readdatavalid, 1);
    chk("r_d0", m0_readdata, 32'hDEAD_BEEF);
    chk("r_d1_shared", m1_readdata, 32'hDEAD_BEEF);
    chk("r_rdv1", m1_readdatavalid, 0);
    // m1 partial byteenable write over all-ones
    @(negedge clk); idle();
    m1_write = 1; m1_address = 10'h3FF; m1_writedata = 32'hFFFF_FFFF; m1_byteenable = 4'hF;
    @(negedge clk); m1_writedata = 32'h1234_5678; m1_byteenable = 4'h3; #1;
    chk("be_wait1", m1_waitrequest, 0);
    @(negedge clk); idle(); m1_read = 1; m1_address = 10'h3FF;
    @(negedge clk); idle(); #1;
    chk("be_rdv1", m1_readdatavalid, 1);
    chk("be_d1", m1_readdata, 32'hFFFF_5678);
    chk("be_rdv0", m0_readdatavalid, 0);
    // simultaneous m0 read / m1 write to 0x100, last grant was m1
    @(negedge clk); idle();
    m0_read = 1; m0_address = 10'h100;
    m1_write = 1; m1_address = 10'h100; m1_writedata = 32'hCAFE_F00D; m1_byteenable = 4'hF;
    #1;
    chk("col_wait0", m0_waitrequest, 0);
    chk("col_wait1", m1_waitrequest, 1);
    chk("col_wr", ram_write, 0);
    @(negedge clk); m0_read = 0; m0_address = '0; #1;
    chk("col_wait1b", m1_waitrequest, 0);
    chk("col_wrb", ram_write, 1);
    chk("col_rdv0", m0_readdatavalid, 1);
    chk("col_old", m0_readdata, 32'hC0DE_0100);
    @(negedge clk); idle(); m0_read = 1; m0_address = 10'h100;
    @(negedge clk); idle(); #1;
    chk("col_new_rdv", m0_readdatavalid, 1);
    chk("col_new", m0_readdata, 32'hCAFE_F00D);
    // read accepted, then reset in the return cycle
    @(negedge clk); idle(); m0_read = 1; m0_address = 10'h005; #1;
    chk("rr_acc", m0_waitrequest, 0);
    @(negedge clk); reset_n = 0; m1_read = 1; #1;
    chk("rs_rdv0", m0_readdatavalid, 0);
    chk("rs_wait0", m0_waitrequest, 1);
    chk("rs_wait1", m1_waitrequest, 1);
    chk("rs_cs", ram_chipselect, 0);
    @(negedge clk); reset_n = 1; m0_read = 1; m1_read = 1; #1;
    chk("rs_first0", m0_waitrequest, 0);
    chk("rs_first1", m1_waitrequest, 1);
    chk("rs_norv", m0_readdatavalid, 0);
    @(negedge clk); m0_address = 10'h006; #1;
    chk("rs_second1", m1_waitrequest, 0);
    // read+write together is a write
    @(negedge clk); idle();
    m0_read = 1; m0_write = 1; m0_address = 10'h00A; m0_writedata = 32'h0BAD_F00D; m0_byteenable = 4'hF;
    #1;
    chk("rw_wr", ram_write, 1);
    chk("rw_wait0", m0_waitrequest, 0);
    @(negedge clk); idle(); #1;
    chk("rw_nordv0", m0_readdatavalid, 0);
    chk("rw_nordv1", m1_readdatavalid, 0);
    @(negedge clk); m0_read = 1; m0_address = 10'h00A;
    @(negedge clk); idle(); #1;
    chk("rw_rdv", m0_readdatavalid, 1);
    chk("rw_data", m0_readdata, 32'h0BAD_F00D);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicore_onchip_arbiter.md
Name: multicore_onchip_arbiter

Overview:
- Two-master round-robin arbiter that shares the single-port 1024x32 on-chip RAM between the two processor data masters of the multicore system.
- Presents two pipelined Avalon-MM slave ports with waitrequest and readdatavalid.
- Drives the RAM's address, byteenable, chipselect, write, writedata and clken.
- Routes the RAM's one-cycle-latency read data back to the master that issued the read.

Parameters:
- ADDR_W, 10, word address width (RAM depth 2^ADDR_W).
- DATA_W, 32, data width.
- BE_W, DATA_W/8, byteenable width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  BE_W  master 0 byte lanes
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data strobe
- m1_*  (same set as m0_*)  master 1
- ram_address  out  ADDR_W  RAM address
- ram_byteenable  out  BE_W  RAM byte lanes
- ram_chipselect  out  1  RAM select
- ram_write  out  1  RAM write enable
- ram_writedata  out  DATA_W  RAM write data
- ram_clken  out  1  RAM clock enable
- ram_readdata  in  DATA_W  RAM q, valid one cycle after the address edge

Behaviour:
- Request: req_i = mi_read | mi_write. Read and write asserted together: treated as a write; read ignored.
- Grant is combinational within the request cycle, so an uncontended access completes with zero wait states.
- Granted master drives the ram_* outputs. ram_chipselect = granted request; ram_write = granted write.
- No grant: ram_chipselect=0, ram_write=0. Other ram_* hold the last granted values (registered mux select), never X.
- ram_clken = 1 whenever reset_n=1; ram_clken = 0 during reset.
- mi_waitrequest = req_i & ~grant_i. Masters hold request signals stable while waitrequest=1 (Avalon rule; not checked).
- Round-robin:
  - Register last_grant (0/1), reset to 1 so master 0 wins the first contention.
  - Single requester: granted immediately.
  - Both requesting: grant goes to the master != last_grant.
  - last_grant updates only on a cycle with a grant.
- Throughput: one accepted access per cycle. Back-to-back contention alternates m0, m1, m0, ...
- Read return:
  - Accepted read at edge N: register rd_pend=1 and rd_owner=i.
  - In cycle N+1: mi_readdatavalid = rd_pend & (rd_owner==i); mi_readdata = ram_readdata.
  - Both mi_readdata outputs carry ram_readdata at all times; only readdatavalid is qualified.
  - Pipelined reads: a read accepted every cycle gives readdatavalid every following cycle, strictly in order.
- Writes produce no readdatavalid. A write granted while the previous read's data returns is legal (single-port RAM, latched output).
- Read-after-write to the same address on consecutive cycles returns the new data (RAM write completes at the edge).
- Reset (reset_n=0 at an edge):
  - rd_pend=0, last_grant=1.
  - While reset_n=0: both waitrequest=1, no grants, ram_chipselect=0, ram_write=0, both readdatavalid=0.
  - A read accepted in the cycle before reset asserts has its readdatavalid suppressed if reset_n=0 in the return cycle.
- Reset values (registered): rd_pend=0, rd_owner=0, last_grant=1, held mux select=0.

Decomposition:
- Shared package multicore_mem_pkg: ADDR_W/DATA_W defaults, master index constants M0=0 / M1=1.
- Sub-module rr_arb2: 2-way round-robin grant logic with last_grant register; inputs req[1:0], advance; output gnt[1:0] (one-hot or zero).
- Top-level holds the mux, read-owner tracking and waitrequest.

Test Plan:
- m0 write addr 0x005 data 0xDEADBEEF be=0xF, then m0 read 0x005 -> zero waits; readdatavalid on m0 one cycle after the read, readdata 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both read every cycle for 6 cycles from reset (m0 addr 0x010.., m1 addr 0x020..) -> grants m0,m1,m0,m1,m0,m1; each waitrequest high on alternate cycles; each master gets 3 valid reads with the correct data, in order.
- m1 write 0x3FF data 0x12345678 be=0x3 over prefilled 0xFFFFFFFF, then m1 read 0x3FF -> 0xFFFF5678.
- m0 read and m1 write to the same address 0x100 simultaneously, last_grant=1 -> m0 reads old data, m1 write lands the following cycle; a later read returns the new data.
- m0 read accepted, reset_n=0 next cycle -> no readdatavalid; both waitrequest=1, ram_chipselect=0 during reset; after release, first contention grants m0.
- m0 asserts read+write together to 0x00A -> write performed, no readdatavalid.
